// File: rtl/shift_rx_pkg.sv
// ============================================================================
// Module      : shift_rx_pkg
// Description : Shared types and sizing helpers for the shift_rx receiver.
//               Optional feature macro: SHIFT_RX_PARITY_EN (trailing even
//               parity bit appended to every frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_rx_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

`ifdef SHIFT_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Frame length in bits for a given data width
    function automatic int flen_f(input int bits);
        return bits + PARITY_BITS;
    endfunction

    // Bit-counter width able to hold 0..flen
    function automatic int cnt_w_f(input int flen);
        return $clog2(flen + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_rx_hold.sv
// ============================================================================
// Module      : shift_rx_hold
// Description : Output holding register with valid/ready handshake. Accepts a
//               committed word when empty or being drained this cycle;
//               otherwise drops it and pulses overrun.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rx_hold
    import shift_rx_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_commit,
    input  logic [BITS-1:0] i_word,
    input  logic            i_par_ready,
    output logic [BITS-1:0] o_par_data,
    output logic            o_par_valid,
    output logic            o_overrun
);

    logic [BITS-1:0] r_data;
    logic            r_valid;
    logic            r_overrun;

    // Load on commit when a slot is free (including back-to-back drain), else flag overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_commit) begin
                if (!r_valid || i_par_ready) begin
                    r_data  <= i_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_par_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_par_data  = r_data;
    assign o_par_valid = r_valid;
    assign o_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: rtl/shift_rx.sv
// ============================================================================
// Module      : shift_rx
// Description : Serial-to-parallel receiver. Collects MSB-first bits with an
//               end-of-shift strobe, checks frame length, and presents the
//               word behind a valid/ready holding register.
//               Optional feature macro: SHIFT_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rx
    import shift_rx_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ser_in,
    input  logic            i_ser_valid,
    input  logic            i_ser_eos,
    output logic [BITS-1:0] o_par_data,
    output logic            o_par_valid,
    input  logic            i_par_ready,
    output logic            o_frame_err,
    output logic            o_overrun,
    output logic            o_parity_err
);

    localparam int FLEN    = flen_f(BITS);
    localparam int CNT_W   = cnt_w_f(FLEN);
    // Only the bits needed before the final one are stored; the last bit is
    // taken straight from the input at the end-of-shift cycle.
    localparam int SHREG_W = FLEN - 1;

    state_t             r_state;
    logic [SHREG_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_frame_err;
    logic               r_parity_err;

    state_t             w_state_nxt;
    logic [SHREG_W-1:0] w_shreg_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SHREG_W:0]   w_cat;
    logic [SHREG_W-1:0] w_shift;
    logic [CNT_W-1:0]   w_len;
    logic               w_last;
    logic               w_par_ok;
    logic [BITS-1:0]    w_word;
    logic               w_commit;
    logic               w_ferr;
    logic               w_perr;

    assign w_cat   = {r_shreg, i_ser_in};
    assign w_shift = w_cat[SHREG_W-1:0];

`ifdef SHIFT_RX_PARITY_EN
    // Even parity: all frame bits XOR to zero; data is the stored leading bits
    assign w_par_ok = ~(^w_cat);
    assign w_word   = r_shreg;
`else
    assign w_par_ok = 1'b1;
    assign w_word   = w_cat;
`endif

    // Length of the frame including the bit presented this cycle
    assign w_len  = (r_state == IDLE) ? CNT_W'(1) : (r_cnt + CNT_W'(1));
    assign w_last = (w_len == CNT_W'(FLEN));

    // Next-state, shift and frame-check decode
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        w_ferr      = 1'b0;
        w_perr      = 1'b0;
        case (r_state)
            IDLE, SHIFT: begin
                if (i_ser_valid) begin
                    w_shreg_nxt = w_shift;
                    w_cnt_nxt   = w_len;
                    if (i_ser_eos) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        if (w_last) begin
                            if (w_par_ok) begin
                                w_commit = 1'b1;
                            end else begin
                                w_perr = 1'b1;
                            end
                        end else begin
                            w_ferr = 1'b1;
                        end
                    end else if (w_last) begin
                        // Frame ran past its length without eos: discard the rest
                        w_ferr      = 1'b1;
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            FLUSH: begin
                if (i_ser_valid && i_ser_eos) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM, shift register, counter and registered error pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame_err  <= w_ferr;
            r_parity_err <= w_perr;
        end
    end

    shift_rx_hold #(
        .BITS (BITS)
    ) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_commit    (w_commit),
        .i_word      (w_word),
        .i_par_ready (i_par_ready),
        .o_par_data  (o_par_data),
        .o_par_valid (o_par_valid),
        .o_overrun   (o_overrun)
    );

    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;

endmodule

`default_nettype wire

// File: tb/tb_shift_rx.sv
// ============================================================================
// Module      : tb_shift_rx
// Description : Scoreboard bench for shift_rx. The driver feeds frames and a
//               frame-level model pushes expected transfers and pulses (with
//               the cycle they must appear in); a negedge monitor pops and
//               compares them. Honors SHIFT_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_rx;

    localparam int BITS = 8;
`ifdef SHIFT_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FLEN = BITS + (PAR_EN ? 1 : 0);

    typedef struct {
        int              c;
        logic [BITS-1:0] d;
    } xfer_t;

    logic            clk;
    logic            rst_n;
    logic            i_ser_in;
    logic            i_ser_valid;
    logic            i_ser_eos;
    logic [BITS-1:0] o_par_data;
    logic            o_par_valid;
    logic            i_par_ready;
    logic            o_frame_err;
    logic            o_overrun;
    logic            o_parity_err;

    shift_rx #(.BITS(BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ser_in     (i_ser_in),
        .i_ser_valid  (i_ser_valid),
        .i_ser_eos    (i_ser_eos),
        .o_par_data   (o_par_data),
        .o_par_valid  (o_par_valid),
        .i_par_ready  (i_par_ready),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_parity_err (o_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    int rdy_pct  = 100;

    xfer_t q_xfer[$];
    int    q_ferr[$];
    int    q_ovr[$];
    int    q_perr[$];

    // Model state: bits of the frame in progress, flush flag, holding slot
    bit              m_bits[$];
    bit              m_flush = 1'b0;
    bit              m_full  = 1'b0;
    logic [BITS-1:0] m_word  = '0;

    function automatic logic rdy_f();
        return ($urandom_range(99) < rdy_pct);
    endfunction

    // Apply one cycle of inputs and predict its consequences
    task automatic step(input logic v, input logic b, input logic e, input logic r, input logic rn);
        bit              full_pre;
        bit              par;
        logic [BITS-1:0] w;
        @(posedge clk);
        #1;
        i_ser_valid = v;
        i_ser_in    = b;
        i_ser_eos   = e;
        i_par_ready = r;
        rst_n       = rn;
        full_pre    = m_full;
        if (m_full && r) begin
            q_xfer.push_back('{c: cyc, d: m_word});
            m_full = 1'b0;
        end
        if (!rn) begin
            m_full  = 1'b0;
            m_flush = 1'b0;
            m_bits.delete();
            return;
        end
        if (!v) return;
        if (m_flush) begin
            if (e) m_flush = 1'b0;
            return;
        end
        m_bits.push_back(b);
        if (e) begin
            if (m_bits.size() == FLEN) begin
                par = 1'b0;
                foreach (m_bits[k]) par ^= m_bits[k];
                w = '0;
                for (int k = 0; k < BITS; k++) w = {w[BITS-2:0], m_bits[k]};
                if (PAR_EN && par) begin
                    q_perr.push_back(cyc + 1);
                end else if (!full_pre || r) begin
                    m_full = 1'b1;
                    m_word = w;
                end else begin
                    q_ovr.push_back(cyc + 1);
                end
            end else begin
                q_ferr.push_back(cyc + 1);
            end
            m_bits.delete();
        end else if (m_bits.size() == FLEN) begin
            q_ferr.push_back(cyc + 1);
            m_bits.delete();
            m_flush = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), rdy_f(), 1'b1);
    endtask

    // Send a frame of len bits (data MSB first, then parity), eos on the last bit
    task automatic send_frame(input logic [BITS-1:0] d, input int len, input int gap, input bit bad_par);
        bit q[$];
        for (int k = BITS - 1; k >= 0; k--) q.push_back(d[k]);
        if (PAR_EN) q.push_back((^d) ^ bad_par);
        while (q.size() < len) q.push_back(1'($urandom_range(1)));
        while (q.size() > len) void'(q.pop_back());
        foreach (q[k]) begin
            idle($urandom_range(gap));
            step(1'b1, q[k], (k == len - 1), rdy_f(), 1'b1);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a transfer or pulse
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_par_valid && i_par_ready) begin
                checks++;
                if (q_xfer.size() == 0) begin
                    failures++;
                    $display("FAIL xfer: unexpected word %0h at cycle %0d", o_par_data, cyc);
                end else begin
                    xfer_t x;
                    x = q_xfer.pop_front();
                    if (x.c != cyc || x.d !== o_par_data) begin
                        failures++;
                        $display("FAIL xfer: got %0h at cycle %0d expected %0h at cycle %0d",
                                 o_par_data, cyc, x.d, x.c);
                    end
                end
            end
            if (o_frame_err) begin
                checks++;
                if (q_ferr.size() == 0 || q_ferr[0] != cyc) begin
                    failures++;
                    $display("FAIL frame_err: pulse at cycle %0d expected %0d", cyc,
                             (q_ferr.size() == 0) ? -1 : q_ferr[0]);
                end
                if (q_ferr.size() != 0) void'(q_ferr.pop_front());
            end
            if (o_overrun) begin
                checks++;
                if (q_ovr.size() == 0 || q_ovr[0] != cyc) begin
                    failures++;
                    $display("FAIL overrun: pulse at cycle %0d expected %0d", cyc,
                             (q_ovr.size() == 0) ? -1 : q_ovr[0]);
                end
                if (q_ovr.size() != 0) void'(q_ovr.pop_front());
            end
            if (o_parity_err) begin
                checks++;
                if (q_perr.size() == 0 || q_perr[0] != cyc) begin
                    failures++;
                    $display("FAIL parity_err: pulse at cycle %0d expected %0d", cyc,
                             (q_perr.size() == 0) ? -1 : q_perr[0]);
                end
                if (q_perr.size() != 0) void'(q_perr.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_par_valid"},  32'(o_par_valid),  32'h0);
        chk({tag, "_par_data"},   32'(o_par_data),   32'h0);
        chk({tag, "_frame_err"},  32'(o_frame_err),  32'h0);
        chk({tag, "_overrun"},    32'(o_overrun),    32'h0);
        chk({tag, "_parity_err"}, 32'(o_parity_err), 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_ser_in    = 1'b0;
        i_ser_valid = 1'b0;
        i_ser_eos   = 1'b0;
        i_par_ready = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_reset_outputs("reset");
        mon_en = 1'b1;

        // Nominal frame, then same frame with 3-cycle gaps
        rdy_pct = 100;
        send_frame(8'hA5, FLEN, 0, 1'b0);
        idle(3);
        for (int k = 0; k < FLEN; k++) begin
            send_frame(8'hA5, FLEN, 0, 1'b0);
            break;
        end
        idle(2);
        begin
            bit q[$];
            for (int k = BITS - 1; k >= 0; k--) q.push_back(k[0] ^ k[2]);
            if (PAR_EN) q.push_back(1'b0);
        end
        send_frame(8'hA5, FLEN, 3, 1'b0);
        idle(3);

        // Short frame, then long frame flushed, then a good frame
        send_frame(8'h5A, 5, 0, 1'b0);
        idle(2);
        send_frame(8'h77, FLEN + 3, 1, 1'b0);
        idle(2);
        send_frame(8'h96, FLEN, 0, 1'b0);
        idle(3);

        // Backpressure: second word overruns, first kept until accepted
        rdy_pct = 0;
        send_frame(8'h3C, FLEN, 0, 1'b0);
        send_frame(8'hC3, FLEN, 0, 1'b0);
        idle(3);
        rdy_pct = 100;
        idle(3);

        // Reset in the middle of a frame, then a clean frame
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_reset_outputs("midreset");
        send_frame(8'h81, FLEN, 0, 1'b0);
        idle(3);

        // Bad parity frame (only meaningful with parity enabled)
        if (PAR_EN) begin
            send_frame(8'hA5, FLEN, 0, 1'b1);
            idle(3);
        end

        // Randomized traffic
        rdy_pct = 60;
        for (int n = 0; n < 200; n++) begin
            int len;
            len = ($urandom_range(99) < 70) ? FLEN : int'($urandom_range(FLEN + 2, 1));
            send_frame(8'($urandom), len, 2, PAR_EN && ($urandom_range(9) == 0));
            if ($urandom_range(3) == 0) idle($urandom_range(4));
        end

        // Drain the holding register and let final pulses land
        rdy_pct = 100;
        idle(6);
        mon_en = 1'b0;
        chk("xfer_queue_empty",   32'(q_xfer.size()), 32'h0);
        chk("ferr_queue_empty",   32'(q_ferr.size()), 32'h0);
        chk("ovr_queue_empty",    32'(q_ovr.size()),  32'h0);
        chk("perr_queue_empty",   32'(q_perr.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
